// File: rtl/riscv_dift_violation_ctrl_if.sv
// Bundle between the DIFT violation controller and its neighbours: the ID/EX
// violation strobes and tag check register, the trap req/ack handshake with
// the core controller, the cause/save pair for the CSR block, and the
// software-visible violation counter.
//
// The slave modport is the violation controller itself; the master modport is
// the surrounding core (pipeline, controller, CSR file) that drives the
// strobes and consumes the trap request.
interface riscv_dift_violation_ctrl_if #(
   parameter int unsigned N_CHECKS  = 5,
   parameter int unsigned CNT_WIDTH = 16
);

   // Pipeline / CSR configuration towards the controller
   logic [31:0]          tcr_i;
   logic [N_CHECKS-1:0]  viol_i;
   logic [31:0]          viol_pc_i;

   // Trap handshake with the core controller
   logic                 dift_exc_req_o;
   logic                 dift_exc_ack_i;
   logic                 exc_restore_i;

   // Cause/save pair for mcause
   logic [5:0]           exc_cause_o;
   logic                 save_exc_cause_o;
   logic [31:0]          viol_pc_o;

   // Software-visible statistics
   logic [CNT_WIDTH-1:0] viol_cnt_o;
   logic                 viol_ovf_o;
   logic                 clr_cnt_i;

   modport master (
      output tcr_i, viol_i, viol_pc_i, dift_exc_ack_i, exc_restore_i, clr_cnt_i,
      input  dift_exc_req_o, exc_cause_o, save_exc_cause_o, viol_pc_o,
             viol_cnt_o, viol_ovf_o
   );

   modport slave (
      input  tcr_i, viol_i, viol_pc_i, dift_exc_ack_i, exc_restore_i, clr_cnt_i,
      output dift_exc_req_o, exc_cause_o, save_exc_cause_o, viol_pc_o,
             viol_cnt_o, viol_ovf_o
   );

endinterface

// File: rtl/riscv_dift_violation_ctrl.sv
// DIFT violation controller.
// Masks the per-check violation strobes from ID/EX with the tag check register,
// latches the highest-priority (lowest index) enabled violation together with
// its PC, and raises a trap request towards the core controller. Once the
// controller acknowledges, the cause is handed to the CSR block with a
// one-cycle save strobe and the block waits for the handler to return.
// A saturating counter with a sticky overflow flag records every enabled
// violation for software, including those that arrive while a trap is pending.
module riscv_dift_violation_ctrl #(
   parameter int unsigned N_CHECKS   = 5,
   parameter int unsigned CNT_WIDTH  = 16,
   parameter logic [5:0]  CAUSE_BASE = 6'h18,
   parameter int unsigned GLB_EN_BIT = 31
) (
   input logic                       clk,
   input logic                       rst,
   riscv_dift_violation_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      BUSY = 2'd2
   } state_e;

   state_e               state_q;
   state_e               state_d;

   logic [N_CHECKS-1:0]  masked;
   logic                 any_viol;
   logic                 glb_en;
   logic [2:0]           win_idx;
   logic [5:0]           win_cause;

   logic                 latch_en;
   logic                 req;
   logic                 save;

   logic [5:0]           cause_q;
   logic [31:0]          pc_q;
   logic [CNT_WIDTH-1:0] cnt_q;
   logic                 ovf_q;
   logic                 cnt_at_max;

   // Only the check enables and the global enable of tcr matter here; the
   // remaining bits belong to other DIFT features.
   logic                 unused_tcr;
   assign unused_tcr = ^bus.tcr_i;

   assign glb_en   = bus.tcr_i[GLB_EN_BIT];
   assign masked   = bus.viol_i & bus.tcr_i[N_CHECKS-1:0] & {N_CHECKS{glb_en}};
   assign any_viol = |masked;

   // Lowest set index wins: scan from the top so the last hit is the lowest.
   always_comb begin
      // NOTE: every variable written here gets a default first, so no path
      // can leave it unassigned and infer a latch.
      win_idx = 3'd0;
      for (int i = N_CHECKS - 1; i >= 0; i--) begin
         if (masked[i]) begin
            win_idx = 3'(i);
         end
      end
   end

   assign win_cause = CAUSE_BASE + {3'b000, win_idx};

   // FSM state register; reset drops req and the save strobe asynchronously
   // because both are decoded from the state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples pre-edge values regardless of block ordering.
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state and handshake outputs.
   always_comb begin
      state_d  = state_q;
      latch_en = 1'b0;
      req      = 1'b0;
      save     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (any_viol) begin
               latch_en = 1'b1;
               state_d  = REQ;
            end
         end
         REQ: begin
            req = 1'b1;
            // Ack takes precedence over a global disable in the same cycle:
            // the controller has already committed to the trap.
            if (bus.dift_exc_ack_i) begin
               save    = 1'b1;
               state_d = BUSY;
            end else if (!glb_en) begin
               state_d = IDLE;
            end
         end
         BUSY: begin
            // A violation arriving with restore is counted but never latched,
            // since latching only happens from IDLE.
            if (bus.exc_restore_i) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Cause and PC of the trapping violation; held until the next latch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cause_q <= 6'd0;
         pc_q    <= 32'd0;
      end else if (latch_en) begin
         cause_q <= win_cause;
         pc_q    <= bus.viol_pc_i;
      end
   end

   assign cnt_at_max = (cnt_q == {CNT_WIDTH{1'b1}});

   // Saturating violation counter and sticky overflow; clear wins over both.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else if (bus.clr_cnt_i) begin
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else if (any_viol) begin
         if (cnt_at_max) begin
            ovf_q <= 1'b1;
         end else begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
         end
         // A violation seen while a trap is outstanding is dropped.
         if (state_q != IDLE) begin
            ovf_q <= 1'b1;
         end
      end
   end

   assign bus.dift_exc_req_o   = req;
   assign bus.save_exc_cause_o = save;
   assign bus.exc_cause_o      = cause_q;
   assign bus.viol_pc_o        = pc_q;
   assign bus.viol_cnt_o       = cnt_q;
   assign bus.viol_ovf_o       = ovf_q;

endmodule

// File: tb/tb_riscv_dift_violation_ctrl.sv
// Testbench for riscv_dift_violation_ctrl.
// Directed vectors drive the default-parameter instance (u_dut) and a
// CNT_WIDTH=2 instance (u_dut2) for counter saturation. Expected cause/PC
// pairs of u_dut are queued when a violation is issued; a monitor pops and
// compares them whenever the DUT raises its save strobe.
module tb_riscv_dift_violation_ctrl;

   typedef struct {
      logic [5:0]  cause;
      logic [31:0] pc;
   } exp_t;

   logic clk;
   logic rst;

   int   n_cmp;
   int   n_err;
   exp_t sb_q[$];

   riscv_dift_violation_ctrl_if #(.N_CHECKS(5), .CNT_WIDTH(16)) b1 ();
   riscv_dift_violation_ctrl_if #(.N_CHECKS(5), .CNT_WIDTH(2))  b2 ();

   riscv_dift_violation_ctrl #(
      .N_CHECKS(5), .CNT_WIDTH(16), .CAUSE_BASE(6'h18), .GLB_EN_BIT(31)
   ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (b1.slave)
   );

   riscv_dift_violation_ctrl #(
      .N_CHECKS(5), .CNT_WIDTH(2), .CAUSE_BASE(6'h18), .GLB_EN_BIT(31)
   ) u_dut2 (
      .clk (clk),
      .rst (rst),
      .bus (b2.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Drive point: 1 time unit after the rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Sample point: falling edge, well away from the active edge.
   task automatic smp();
      @(negedge clk);
   endtask

   task automatic push(input logic [5:0] cause, input logic [31:0] pc);
      exp_t e;
      e.cause = cause;
      e.pc    = pc;
      sb_q.push_back(e);
   endtask

   // Scoreboard monitor: every save strobe of u_dut must match the oldest
   // expected trap.
   always @(negedge clk) begin
      if (b1.save_exc_cause_o === 1'b1) begin
         if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_unexpected_save: got cause 0x%0h pc 0x%0h, expected no save",
                     b1.exc_cause_o, b1.viol_pc_o);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("sb_cause", {26'd0, b1.exc_cause_o}, {26'd0, e.cause});
            check("sb_pc", b1.viol_pc_o, e.pc);
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst   = 1'b1;
      {b1.tcr_i, b1.viol_i, b1.viol_pc_i} = '0;
      {b1.dift_exc_ack_i, b1.exc_restore_i, b1.clr_cnt_i} = '0;
      {b2.tcr_i, b2.viol_i, b2.viol_pc_i} = '0;
      {b2.dift_exc_ack_i, b2.exc_restore_i, b2.clr_cnt_i} = '0;

      // Reset state
      #2;
      check("rst_req",   {31'd0, b1.dift_exc_req_o},   32'd0);
      check("rst_save",  {31'd0, b1.save_exc_cause_o}, 32'd0);
      check("rst_cause", {26'd0, b1.exc_cause_o},      32'd0);
      check("rst_pc",    b1.viol_pc_o,                 32'd0);
      check("rst_cnt",   {16'd0, b1.viol_cnt_o},       32'd0);
      check("rst_ovf",   {31'd0, b1.viol_ovf_o},       32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      cyc();

      // 1. Single violation on check 2, ack, restore
      b1.tcr_i = 32'h8000_0004; b1.viol_i = 5'b00100; b1.viol_pc_i = 32'h100;
      push(6'h1A, 32'h100);
      smp();
      check("t1_req_latency", {31'd0, b1.dift_exc_req_o}, 32'd0);
      cyc();
      b1.viol_i = '0;
      smp();
      check("t1_req",   {31'd0, b1.dift_exc_req_o}, 32'd1);
      check("t1_cause", {26'd0, b1.exc_cause_o},    32'h1A);
      check("t1_pc",    b1.viol_pc_o,               32'h100);
      check("t1_cnt",   {16'd0, b1.viol_cnt_o},     32'd1);
      cyc();
      check("t1_req_stable", {31'd0, b1.dift_exc_req_o}, 32'd1);
      b1.dift_exc_ack_i = 1'b1;
      smp();
      check("t1_save", {31'd0, b1.save_exc_cause_o}, 32'd1);
      cyc();
      b1.dift_exc_ack_i = 1'b0;
      smp();
      check("t1_save_1cyc", {31'd0, b1.save_exc_cause_o}, 32'd0);
      check("t1_req_busy",  {31'd0, b1.dift_exc_req_o},   32'd0);
      b1.exc_restore_i = 1'b1;
      cyc();
      b1.exc_restore_i = 1'b0;

      // 2. Two checks at once: lowest index wins
      b1.clr_cnt_i = 1'b1;
      cyc();
      b1.clr_cnt_i = 1'b0;
      b1.tcr_i = 32'h8000_0006; b1.viol_i = 5'b00110; b1.viol_pc_i = 32'h200;
      push(6'h19, 32'h200);
      cyc();
      b1.viol_i = '0;
      smp();
      check("t2_req",   {31'd0, b1.dift_exc_req_o}, 32'd1);
      check("t2_cause", {26'd0, b1.exc_cause_o},    32'h19);
      check("t2_cnt",   {16'd0, b1.viol_cnt_o},     32'd1);
      cyc();
      b1.dift_exc_ack_i = 1'b1;
      smp();
      check("t2_save", {31'd0, b1.save_exc_cause_o}, 32'd1);
      cyc();
      b1.dift_exc_ack_i = 1'b0;

      // 3. Violation while BUSY, violation together with restore, then retrap
      b1.viol_i = 5'b00010; b1.viol_pc_i = 32'h250;
      cyc();
      b1.viol_i = '0;
      smp();
      check("t3_busy_req",   {31'd0, b1.dift_exc_req_o}, 32'd0);
      check("t3_busy_cnt",   {16'd0, b1.viol_cnt_o},     32'd2);
      check("t3_busy_ovf",   {31'd0, b1.viol_ovf_o},     32'd1);
      check("t3_busy_cause", {26'd0, b1.exc_cause_o},    32'h19);
      check("t3_busy_pc",    b1.viol_pc_o,               32'h200);
      b1.exc_restore_i = 1'b1; b1.viol_i = 5'b00100; b1.viol_pc_i = 32'h260;
      cyc();
      b1.exc_restore_i = 1'b0; b1.viol_i = '0;
      smp();
      check("t3_rest_req", {31'd0, b1.dift_exc_req_o}, 32'd0);
      check("t3_rest_cnt", {16'd0, b1.viol_cnt_o},     32'd3);
      check("t3_rest_pc",  b1.viol_pc_o,               32'h200);
      cyc();
      b1.dift_exc_ack_i = 1'b1;
      smp();
      check("t3_idle_ack", {31'd0, b1.save_exc_cause_o}, 32'd0);
      cyc();
      b1.dift_exc_ack_i = 1'b0;
      b1.viol_i = 5'b00100; b1.viol_pc_i = 32'h300;
      push(6'h1A, 32'h300);
      cyc();
      b1.viol_i = '0;
      smp();
      check("t3_req",   {31'd0, b1.dift_exc_req_o}, 32'd1);
      check("t3_cause", {26'd0, b1.exc_cause_o},    32'h1A);
      check("t3_pc",    b1.viol_pc_o,               32'h300);
      check("t3_cnt",   {16'd0, b1.viol_cnt_o},     32'd4);
      cyc();
      b1.dift_exc_ack_i = 1'b1;
      smp();
      check("t3_save", {31'd0, b1.save_exc_cause_o}, 32'd1);
      cyc();
      b1.dift_exc_ack_i = 1'b0; b1.exc_restore_i = 1'b1;
      cyc();
      b1.exc_restore_i = 1'b0;

      // 4. Global disable withdraws the request; ack beats disable
      b1.clr_cnt_i = 1'b1;
      cyc();
      b1.clr_cnt_i = 1'b0;
      b1.tcr_i = 32'h8000_0001; b1.viol_i = 5'b00001; b1.viol_pc_i = 32'h400;
      cyc();
      b1.viol_i = '0;
      smp();
      check("t4_req",   {31'd0, b1.dift_exc_req_o}, 32'd1);
      check("t4_cause", {26'd0, b1.exc_cause_o},    32'h18);
      check("t4_pc",    b1.viol_pc_o,               32'h400);
      cyc();
      b1.tcr_i = 32'h0000_0001;
      smp();
      check("t4_dis_save", {31'd0, b1.save_exc_cause_o}, 32'd0);
      check("t4_dis_req",  {31'd0, b1.dift_exc_req_o},   32'd1);
      cyc();
      smp();
      check("t4_withdrawn", {31'd0, b1.dift_exc_req_o}, 32'd0);
      b1.tcr_i = 32'h8000_0001;
      cyc();
      b1.viol_i = 5'b00001; b1.viol_pc_i = 32'h500;
      push(6'h18, 32'h500);
      cyc();
      b1.viol_i = '0;
      smp();
      check("t4_retrap_req", {31'd0, b1.dift_exc_req_o}, 32'd1);
      check("t4_retrap_pc",  b1.viol_pc_o,               32'h500);
      check("t4_retrap_cnt", {16'd0, b1.viol_cnt_o},     32'd2);
      check("t4_retrap_ovf", {31'd0, b1.viol_ovf_o},     32'd0);
      cyc();
      b1.dift_exc_ack_i = 1'b1; b1.tcr_i = 32'h0000_0001;
      smp();
      check("t4_ack_wins", {31'd0, b1.save_exc_cause_o}, 32'd1);
      cyc();
      b1.dift_exc_ack_i = 1'b0; b1.tcr_i = 32'h8000_0001;
      smp();
      check("t4_busy_req", {31'd0, b1.dift_exc_req_o}, 32'd0);
      b1.viol_i = 5'b00001; b1.viol_pc_i = 32'h550;
      cyc();
      b1.viol_i = '0;
      smp();
      check("t4_busy_noreq", {31'd0, b1.dift_exc_req_o}, 32'd0);
      check("t4_busy_ovf",   {31'd0, b1.viol_ovf_o},     32'd1);
      check("t4_busy_cnt",   {16'd0, b1.viol_cnt_o},     32'd3);
      b1.exc_restore_i = 1'b1;
      cyc();
      b1.exc_restore_i = 1'b0;

      // 5. CNT_WIDTH=2 saturation, then clear beats increment
      b2.tcr_i = 32'h8000_0008;
      for (int k = 0; k < 4; k++) begin
         b2.viol_i = 5'b01000; b2.viol_pc_i = 32'h1000 + 32'(k * 4);
         cyc();
         b2.viol_i = '0;
         smp();
         check("t5_req", {31'd0, b2.dift_exc_req_o}, 32'd1);
         if (k == 2) begin
            check("t5_cnt_at_3", {30'd0, b2.viol_cnt_o}, 32'd3);
         end
         cyc();
         b2.dift_exc_ack_i = 1'b1;
         cyc();
         b2.dift_exc_ack_i = 1'b0; b2.exc_restore_i = 1'b1;
         cyc();
         b2.exc_restore_i = 1'b0;
      end
      smp();
      check("t5_sat_cnt", {30'd0, b2.viol_cnt_o}, 32'd3);
      check("t5_sat_ovf", {31'd0, b2.viol_ovf_o}, 32'd1);
      check("t5_cause",   {26'd0, b2.exc_cause_o}, 32'h1B);
      check("t5_pc",      b2.viol_pc_o,            32'h100C);
      cyc();
      b2.clr_cnt_i = 1'b1; b2.viol_i = 5'b01000; b2.viol_pc_i = 32'h2000;
      cyc();
      b2.clr_cnt_i = 1'b0; b2.viol_i = '0;
      smp();
      check("t5_clr_cnt", {30'd0, b2.viol_cnt_o}, 32'd0);
      check("t5_clr_ovf", {31'd0, b2.viol_ovf_o}, 32'd0);
      cyc();
      b2.dift_exc_ack_i = 1'b1;
      cyc();
      b2.dift_exc_ack_i = 1'b0; b2.exc_restore_i = 1'b1;
      cyc();
      b2.exc_restore_i = 1'b0;

      // 6. Asynchronous reset while REQ with ack asserted
      b1.tcr_i = 32'h8000_0001; b1.viol_i = 5'b00001; b1.viol_pc_i = 32'h600;
      cyc();
      b1.viol_i = '0;
      smp();
      check("t6_req", {31'd0, b1.dift_exc_req_o}, 32'd1);
      cyc();
      b1.dift_exc_ack_i = 1'b1;
      #1;
      rst = 1'b1;
      #1;
      check("t6_async_req",  {31'd0, b1.dift_exc_req_o},   32'd0);
      check("t6_async_save", {31'd0, b1.save_exc_cause_o}, 32'd0);
      b1.dift_exc_ack_i = 1'b0;
      cyc();
      cyc();
      rst = 1'b0;
      smp();
      check("t6_post_req",   {31'd0, b1.dift_exc_req_o},   32'd0);
      check("t6_post_save",  {31'd0, b1.save_exc_cause_o}, 32'd0);
      check("t6_post_cause", {26'd0, b1.exc_cause_o},      32'd0);
      check("t6_post_pc",    b1.viol_pc_o,                 32'd0);
      check("t6_post_cnt",   {16'd0, b1.viol_cnt_o},       32'd0);
      check("t6_post_ovf",   {31'd0, b1.viol_ovf_o},       32'd0);

      cyc();
      check("sb_drained", 32'(sb_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
